// File: rtl/buzzer_seq.sv
// Beep-pattern scheduler: arbitrates an alarm (hi) and a notify (lo) requester and plays the
// granted pattern of beeps on the buzzer's enable/compare inputs.
module buzzer_seq #(
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned CMP_W    = 22,
  parameter int unsigned DUR_W    = 10,
  parameter int unsigned CNT_W    = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             hi_req_i,
  input  logic [CMP_W-1:0] hi_cmp_i,
  input  logic [DUR_W-1:0] hi_on_i,
  input  logic [DUR_W-1:0] hi_off_i,
  input  logic [CNT_W-1:0] hi_cnt_i,
  input  logic             lo_req_i,
  input  logic [CMP_W-1:0] lo_cmp_i,
  input  logic [DUR_W-1:0] lo_on_i,
  input  logic [DUR_W-1:0] lo_off_i,
  input  logic [CNT_W-1:0] lo_cnt_i,
  input  logic             stop_i,
  output logic             buzzer_en_o,
  output logic [CMP_W-1:0] buzzer_cmp_o,
  output logic             busy_o,
  output logic             grant_hi_o,
  output logic             done_o,
  output logic             drop_o
);

  localparam int unsigned     PreW    = $clog2(TICK_DIV);
  localparam logic [PreW-1:0] PreLast = PreW'(TICK_DIV - 1);

  typedef enum logic [1:0] {StIdle, StOn, StOff} state_e;

  state_e           state_q;
  logic [CMP_W-1:0] cmp_q;
  logic [DUR_W-1:0] on_q, off_q, tick_q;
  logic [CNT_W-1:0] cnt_q;
  logic [PreW-1:0]  pre_q;
  logic             en_q, grant_hi_q, done_q, drop_q;

  logic             busy, accept_hi, accept_lo, accept, drop, phase_end;
  logic [CMP_W-1:0] sel_cmp;
  logic [DUR_W-1:0] sel_on, sel_off, phase_last;
  logic [CNT_W-1:0] sel_cnt;

  always_comb begin
    busy      = (state_q != StIdle);
    // stop wins over everything; hi only preempts a lo pattern; lo never interrupts
    accept_hi = hi_req_i && !stop_i && (!busy || !grant_hi_q);
    accept_lo = lo_req_i && !stop_i && !hi_req_i && !busy;
    accept    = accept_hi || accept_lo;
    drop      = (hi_req_i && !accept_hi) || (lo_req_i && !accept_lo);
    sel_cmp   = accept_hi ? hi_cmp_i : lo_cmp_i;
    sel_on    = accept_hi ? hi_on_i  : lo_on_i;
    sel_off   = accept_hi ? hi_off_i : lo_off_i;
    sel_cnt   = accept_hi ? hi_cnt_i : lo_cnt_i;
    phase_last = ((state_q == StOn) ? on_q : off_q) - DUR_W'(1);
    phase_end  = (pre_q == PreLast) && (tick_q == phase_last);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      cmp_q      <= '0;
      on_q       <= '0;
      off_q      <= '0;
      cnt_q      <= '0;
      pre_q      <= '0;
      tick_q     <= '0;
      en_q       <= 1'b0;
      grant_hi_q <= 1'b0;
      done_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      drop_q <= drop;
      if (accept) begin
        state_q    <= StOn;
        en_q       <= 1'b1;
        grant_hi_q <= accept_hi;
        cmp_q      <= sel_cmp;
        on_q       <= (sel_on == '0) ? DUR_W'(1) : sel_on;
        off_q      <= sel_off;
        cnt_q      <= (sel_cnt == '0) ? CNT_W'(1) : sel_cnt;
        pre_q      <= '0;
        tick_q     <= '0;
      end else if (busy && stop_i) begin
        state_q    <= StIdle;
        en_q       <= 1'b0;
        grant_hi_q <= 1'b0;
        pre_q      <= '0;
        tick_q     <= '0;
      end else if (busy) begin
        if (!phase_end) begin
          if (pre_q == PreLast) begin
            pre_q  <= '0;
            tick_q <= tick_q + DUR_W'(1);
          end else begin
            pre_q <= pre_q + PreW'(1);
          end
        end else begin
          pre_q  <= '0;
          tick_q <= '0;
          if (state_q == StOff) begin
            state_q <= StOn;
            en_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_q    <= StIdle;
              en_q       <= 1'b0;
              grant_hi_q <= 1'b0;
              done_q     <= 1'b1;
            end else if (off_q != '0) begin
              state_q <= StOff;
              en_q    <= 1'b0;
            end
            // off == 0: stay in ON with counters restarted, so beeps merge
          end
        end
      end
    end
  end

  assign buzzer_en_o  = en_q;
  assign buzzer_cmp_o = cmp_q;
  assign busy_o       = (state_q != StIdle);
  assign grant_hi_o   = grant_hi_q;
  assign done_o       = done_q;
  assign drop_o       = drop_q;

endmodule
